// File: rtl/arduino_uart_tx_buffer.sv
// FIFO-buffered 8N1 UART transmitter for the Arduino-facing TX pin.
// Bytes queue through a valid/ready handshake and go out back-to-back.
module arduino_uart_tx_buffer #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk_50,
    input  logic                        reset_n,
    input  logic [7:0]                  data_tx,
    input  logic                        valid,
    output logic                        ready,
    output logic                        uart_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);

    localparam logic [CntW-1:0] BaudLast = CntW'(ClksPerBit - 1);
    localparam logic [PtrW:0]   FullCnt  = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q;
    logic [CntW-1:0] baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            tx_q;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;

    logic push, pop, baud_done;

    assign baud_done = (baud_q == BaudLast);
    // ready depends on registered occupancy only; a pop in a full cycle does not open a slot
    assign ready     = (count_q != FullCnt);
    assign push      = valid && ready;
    assign pop       = (count_q != '0) &&
                       ((state_q == StIdle) || ((state_q == StStop) && baud_done));
    assign count_d   = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);

    always_ff @(posedge clk_50) begin
        if (push) begin
            mem[wr_ptr_q] <= data_tx;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem[rd_ptr_q];
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
                StData: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        // chain straight into the next start bit when more data waits
                        if (pop) begin
                            shift_q <= mem[rd_ptr_q];
                            bit_q   <= '0;
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign uart_out   = tx_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_arduino_uart_tx_buffer.sv
// Directed bench for arduino_uart_tx_buffer at 10 clocks per bit, with a
// line receiver that decodes frames and timestamps every start-bit edge.
module tb_arduino_uart_tx_buffer;

    logic       clk;
    logic       reset_n;
    logic [7:0] data_tx;
    logic       valid;
    logic       ready;
    logic       uart_out;
    logic       busy;
    logic [3:0] fifo_count;

    arduino_uart_tx_buffer #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100),
        .FIFO_DEPTH(8)
    ) dut (
        .clk_50    (clk),
        .reset_n   (reset_n),
        .data_tx   (data_tx),
        .valid     (valid),
        .ready     (ready),
        .uart_out  (uart_out),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int max_cnt  = 0;
    int frame_err = 0;

    int         fall_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Line receiver: samples at bit centres, records fall time of each start bit
    initial begin
        logic       prev;
        logic       active;
        int         cnt;
        logic [7:0] sh;
        prev = 1'b1; active = 1'b0; cnt = 0; sh = '0;
        forever begin
            @(negedge clk);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (!reset_n) begin
                active = 1'b0;
                prev   = 1'b1;
            end else begin
                if (!active) begin
                    if (prev && !uart_out) begin
                        active = 1'b1;
                        cnt    = 0;
                        fall_q.push_back(cyc);
                    end
                end else begin
                    cnt++;
                    if (cnt == 5 && uart_out !== 1'b0) frame_err++;
                    if (cnt >= 15 && cnt <= 85 && (cnt % 10) == 5) sh = {uart_out, sh[7:1]};
                    if (cnt == 95) begin
                        if (uart_out !== 1'b1) frame_err++;
                        rx_q.push_back(sh);
                        active = 1'b0;
                    end
                end
                prev = uart_out;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int k;
        k = 0;
        @(negedge clk);
        data_tx = b;
        valid   = 1'b1;
        while (!ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq("push_ready", int'(ready), 1);
        @(posedge clk);
        #1;
        last_acc = cyc;
        exp_q.push_back(b);
    endtask

    task automatic push_at(input logic [7:0] b, input int target);
        int k;
        k = 0;
        @(negedge clk);
        while (cyc < target - 1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        data_tx = b;
        valid   = 1'b1;
        @(posedge clk);
        #1;
        last_acc = cyc;
        exp_q.push_back(b);
    endtask

    task automatic release_valid();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        while (exp_q.size() > 0) begin
            k = 0;
            while (rx_q.size() == 0 && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (rx_q.size() == 0) begin
                check_eq({tag, "_rx_count"}, rx_q.size(), 1);
                exp_q.delete();
            end else begin
                check_eq(tag, int'(rx_q.pop_front()), int'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_idle_busy"}, int'(busy), 0);
        check_eq({tag, "_idle_line"}, int'(uart_out), 1);
    endtask

    initial begin
        logic [9:0] frame;
        int errs, f0, acc0;

        reset_n = 1'b1;
        valid   = 1'b0;
        data_tx = 8'h00;
        #3 reset_n = 1'b0;
        #1;
        check_eq("rst_uart", int'(uart_out), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_count", int'(fifo_count), 0);
        check_eq("rst_ready", int'(ready), 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte, cycle-exact waveform
        fall_q.delete();
        push_byte(8'hA5);
        release_valid();
        check_eq("a5_high_at_accept", int'(uart_out), 1);
        frame = {1'b1, 8'hA5, 1'b0};
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (uart_out !== frame[k / 10]) errs++;
        end
        check_eq("a5_wave_errors", errs, 0);
        f0 = (fall_q.size() > 0) ? fall_q[0] : -1;
        check_eq("a5_latency", f0 - last_acc, 1);
        @(negedge clk);
        check_eq("a5_after_line", int'(uart_out), 1);
        check_eq("a5_after_busy", int'(busy), 0);
        drain("a5_rx");

        // Burst of three, contiguous frames
        fall_q.delete();
        max_cnt = 0;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        release_valid();
        drain("burst_rx");
        check_eq("burst_peak", max_cnt, 2);
        check_eq("burst_frames", fall_q.size(), 3);
        if (fall_q.size() == 3) begin
            check_eq("burst_gap1", fall_q[1] - fall_q[0], 100);
            check_eq("burst_gap2", fall_q[2] - fall_q[1], 100);
        end
        wait_idle("burst");

        // Fill the FIFO, then stall a tenth byte until the next pop
        fall_q.delete();
        max_cnt = 0;
        for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
        @(negedge clk);
        check_eq("full_count", int'(fifo_count), 8);
        check_eq("full_ready", int'(ready), 0);
        push_byte(8'h19);
        release_valid();
        check_eq("full_accept_after_pop",
                 last_acc - ((fall_q.size() > 1) ? fall_q[1] : 0), 1);
        drain("full_rx");
        check_eq("full_peak", max_cnt, 8);
        wait_idle("full");

        // Push lands on the same edge as a pop with three queued
        fall_q.delete();
        push_byte(8'h41);
        acc0 = last_acc;
        push_byte(8'h42);
        push_byte(8'h43);
        push_byte(8'h44);
        release_valid();
        check_eq("simul_pre_count", int'(fifo_count), 3);
        push_at(8'h45, acc0 + 101);
        release_valid();
        check_eq("simul_count", int'(fifo_count), 3);
        check_eq("simul_acc_edge", last_acc, acc0 + 101);
        check_eq("simul_pop_edge", (fall_q.size() > 1) ? fall_q[1] : -1, acc0 + 101);
        drain("simul_rx");
        wait_idle("simul");

        // Reset during data bit 4 of 0x3C with two bytes queued
        fall_q.delete();
        push_byte(8'h3C);
        acc0 = last_acc;
        push_byte(8'h55);
        push_byte(8'h66);
        release_valid();
        exp_q.delete();
        while (cyc < acc0 + 1 + 55) @(negedge clk);
        #2;
        reset_n = 1'b0;
        valid   = 1'b1;
        data_tx = 8'h99;
        #1;
        check_eq("midrst_uart", int'(uart_out), 1);
        check_eq("midrst_count", int'(fifo_count), 0);
        check_eq("midrst_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        check_eq("midrst_write_ignored", int'(fifo_count), 0);
        valid   = 1'b0;
        reset_n = 1'b1;
        fall_q.delete();
        rx_q.delete();
        repeat (300) @(negedge clk);
        check_eq("midrst_no_frames", fall_q.size(), 0);
        check_eq("midrst_line", int'(uart_out), 1);
        push_byte(8'h7E);
        release_valid();
        drain("midrst_7e");
        wait_idle("midrst");

        // data_tx wiggling with valid low must do nothing
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            data_tx = 8'(i * 37 + 5);
            valid   = 1'b0;
            if (fifo_count != 4'd0 || uart_out !== 1'b1 || busy) errs++;
        end
        check_eq("bp_violations", errs, 0);
        check_eq("bp_count", int'(fifo_count), 0);
        check_eq("frame_errors", frame_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
